nc_mult_sequencer: RTL and testbench
====================================

# nc_mult_sequencer

Command sequencer for the neural core's matrix-multiply datapath. It parses bytes from the UART receiver and writes operand matrices A and B into the array register file. It then starts the multiplier, waits for completion under a timeout, reads back the results and streams them to the UART transmitter. It sits between the UART RX/TX blocks and the multiplier/array inside `NeuralChip`, and it exports the 5-bit state used for the `received_state` debug pins.

## Interface
- `DIM`, default 2: matrix dimension; each operand has DIM×DIM 8-bit entries, and the result has DIM×DIM 16-bit entries.
- `TIMEOUT_CYCLES`, default 1024: maximum number of WAIT cycles before a timeout is declared.
- AW = max(1, clog2(DIM*DIM)); this is a derived width, not a parameter.

Ports (name, direction, width, meaning):
- `CLK` in 1: the single clock; all logic is on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe marking a received byte.
- `rx_data` in 8: the received byte, valid while `rx_valid` is high.
- `arr_we` out 1: array write enable.
- `arr_sel` out 1: operand select, 0 = A, 1 = B.
- `arr_addr` out AW: operand entry index, row-major.
- `arr_wdata` out 8: operand byte.
- `mult_start` out 1: one-cycle start pulse to the multiplier.
- `mult_done` in 1: completion from the multiplier; pulse or level is accepted.
- `res_addr` out AW: result read index.
- `res_data` in 16: result word, valid one cycle after `res_addr`.
- `tx_valid` out 1, `tx_data` out 8, `tx_ready` in 1: byte handshake to the UART TX.
- `state` out 5: {err, st[3:0]}.
- `busy` out 1: high whenever st ≠ IDLE.

## Operation
- Command bytes are accepted only in IDLE:
  - 0xA5: load A (DIM² bytes), then load B (DIM² bytes), then run, then send results.
  - 0x5A: run on the existing arrays, then send results.
  - 0x3C: send results only.
  - Any other byte: ignored, and `err` is set.
- A valid command clears `err`.
- States and their st encoding:
  - IDLE=0, LOAD_A=1, LOAD_B=2, START=3, WAIT=4, FETCH=5, CAPTURE=6, SEND_HI=7, SEND_LO=8, SEND_ERR=9.
- LOAD_A / LOAD_B:
  - Each `rx_valid` byte produces one registered write on the next cycle: `arr_we`=1, `arr_addr`=idx, `arr_wdata`=byte.
  - idx increments from 0 to DIM²−1.
  - After entry DIM²−1 of A, go to LOAD_B with idx=0. After entry DIM²−1 of B, go to START.
  - No load timeout; the sequencer waits indefinitely for bytes.
- START: assert `mult_start` for exactly one cycle, clear the timeout counter, then go to WAIT.
- WAIT:
  - `mult_done`=1 moves to FETCH with result index 0.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: set `err`, go to SEND_ERR.
  - `mult_done` is not sampled in the START cycle.
- FETCH: drive `res_addr`=index. CAPTURE: latch `res_data` into a 16-bit holding register.
- SEND_HI: present the upper byte; hold `tx_valid` and `tx_data` stable until `tx_ready`.
- SEND_LO: present the lower byte the same way. Then:
  - If index = DIM²−1, go to IDLE.
  - Otherwise increment index and go to FETCH.
- SEND_ERR: send 0xEE with the same handshake, then go to IDLE.
- `rx_valid` outside IDLE/LOAD_A/LOAD_B: the byte is dropped, with no other effect.

## Timing
- Reset values: all outputs are 0; st=IDLE, `err`=0, and all counters and indices are 0.
- RESET overrides every other input in the same cycle.
- RESET mid-operation (any state): returns to IDLE on that edge; array contents are not modified.
- Load path latency: `rx_valid` at cycle n gives `arr_we` at n+1.
- Last B byte at cycle n: `mult_start` at n+2 (START state).
- `mult_done` seen at cycle m in WAIT: `res_addr` driven at m+1, data latched at m+2, `tx_valid` high from m+3.
- TX handshake:
  - A byte transfers on the cycle where `tx_valid` and `tx_ready` are both high.
  - `tx_valid` drops or changes byte on the next cycle.
  - `tx_ready` held high: one byte per 1 cycle in SEND states, and each result word costs 4 cycles minimum (FETCH, CAPTURE, HI, LO).
- `tx_valid` never asserts outside the SEND states, and never toggles while waiting for ready.
- Timeout: with no `mult_done`, SEND_ERR is entered exactly TIMEOUT_CYCLES cycles after entering WAIT.
- `mult_done` arriving in the same cycle the timeout expires: done wins; no error.
- `busy` falls on the cycle IDLE is re-entered.

## Test plan
- Reset, then byte 0x12 → `err`=1, `state`=5'b10000, no `arr_we`.
- 0xA5 + A={1,2,3,4} + B={5,6,7,8} (DIM=2) → exactly 8 writes, with sel/addr 0/0..0/3 then 1/0..1/3, data matching; `mult_start` pulses once, 2 cycles after the last byte.
- Continue with `mult_done` 10 cycles after start, res={19,22,43,50}, `tx_ready` tied high → TX bytes 00,13,00,16,00,2B,00,32, then IDLE and `busy`=0.
- Repeat the send phase with `tx_ready` low for 5 random cycles per byte → identical byte sequence, and `tx_data` stable while `tx_valid`=1 and `tx_ready`=0.
- 0x5A with `mult_done` never asserted, TIMEOUT_CYCLES=16 → SEND_ERR entered 16 cycles after WAIT, byte 0xEE sent, `err`=1 persists until the next valid command (0x3C) clears it.
- RESET asserted in LOAD_B after 2 bytes, then 0x3C → st=IDLE, outputs 0; the result stream restarts from index 0 with no writes issued.

Source files
------------

// File: rtl/nc_mult_sequencer.sv
// nc_mult_sequencer: takes command bytes from the UART RX, loads the A/B operand
// arrays, runs the multiplier under a timeout, and streams the 16-bit results to
// the UART TX, high byte first.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a command byte (0xA5 load+run, 0x5A run, 0x3C send)
// LOAD_A   | each received byte becomes one registered write into A
// LOAD_B   | same for B; leaves once the final B write has been issued
// START    | one-cycle mult_start pulse, timeout counter loaded
// WAIT     | waiting for mult_done, counting down toward the timeout
// FETCH    | res_addr driven with the result index
// CAPTURE  | res_data latched into the holding register
// SEND_HI  | upper result byte offered to TX until accepted
// SEND_LO  | lower result byte offered; then next index or back to IDLE
// SEND_ERR | 0xEE offered to TX after a timeout
module nc_mult_sequencer #(
  parameter int DIM            = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int NE            = DIM * DIM,
  localparam int AW            = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          arr_we,
  output logic          arr_sel,
  output logic [AW-1:0] arr_addr,
  output logic [7:0]    arr_wdata,
  output logic          mult_start,
  input  logic          mult_done,
  output logic [AW-1:0] res_addr,
  input  logic [15:0]   res_data,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic [4:0]    state,
  output logic          busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_LOAD_A   = 4'd1;
  localparam logic [3:0] ST_LOAD_B   = 4'd2;
  localparam logic [3:0] ST_START    = 4'd3;
  localparam logic [3:0] ST_WAIT     = 4'd4;
  localparam logic [3:0] ST_FETCH    = 4'd5;
  localparam logic [3:0] ST_CAPTURE  = 4'd6;
  localparam logic [3:0] ST_SEND_HI  = 4'd7;
  localparam logic [3:0] ST_SEND_LO  = 4'd8;
  localparam logic [3:0] ST_SEND_ERR = 4'd9;

  localparam logic [AW-1:0] LAST_IDX = AW'(NE - 1);

  logic [3:0]    st_q, st_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic          we_q, we_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;

  logic idx_last;
  logic b_last_wr;

  assign idx_last  = (idx_q == LAST_IDX);
  // The final B write is in flight this cycle; START follows it so that
  // mult_start never overlaps an array write.
  assign b_last_wr = we_q && sel_q && (addr_q == LAST_IDX);

  // Next-state, index, timeout and array-write decisions.
  always_comb begin
    st_d    = st_q;
    err_d   = err_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (st_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'hA5: begin st_d = ST_LOAD_A; idx_d = '0; err_d = 1'b0; end
            8'h5A: begin st_d = ST_START;              err_d = 1'b0; end
            8'h3C: begin st_d = ST_FETCH;  idx_d = '0; err_d = 1'b0; end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD_A: begin
        if (rx_valid) begin
          we_d    = 1'b1;
          sel_d   = 1'b0;
          addr_d  = idx_q;
          wdata_d = rx_data;
          if (idx_last) begin
            st_d  = ST_LOAD_B;
            idx_d = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (b_last_wr) begin
          st_d = ST_START;
        end else if (rx_valid) begin
          we_d    = 1'b1;
          sel_d   = 1'b1;
          addr_d  = idx_q;
          wdata_d = rx_data;
          idx_d   = idx_last ? '0 : idx_q + AW'(1);
        end
      end
      ST_START: begin
        cnt_d = CW'(TIMEOUT_CYCLES - 1);
        st_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // done is checked first so it wins over an expiring timeout
        if (mult_done) begin
          st_d  = ST_FETCH;
          idx_d = '0;
        end else if (cnt_q == '0) begin
          err_d = 1'b1;
          st_d  = ST_SEND_ERR;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_FETCH:   st_d = ST_CAPTURE;
      ST_CAPTURE: begin
        hold_d = res_data;
        st_d   = ST_SEND_HI;
      end
      ST_SEND_HI: if (tx_ready) st_d = ST_SEND_LO;
      ST_SEND_LO: begin
        if (tx_ready) begin
          if (idx_last) begin
            st_d = ST_IDLE;
          end else begin
            idx_d = idx_q + AW'(1);
            st_d  = ST_FETCH;
          end
        end
      end
      ST_SEND_ERR: if (tx_ready) st_d = ST_IDLE;
      default:     st_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_q    <= ST_IDLE;
      err_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      st_q    <= st_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // TX byte selection, decoded from the state so it cannot change while waiting.
  always_comb begin
    tx_data = 8'h00;
    case (st_q)
      ST_SEND_HI:  tx_data = hold_q[15:8];
      ST_SEND_LO:  tx_data = hold_q[7:0];
      ST_SEND_ERR: tx_data = 8'hEE;
      default:     tx_data = 8'h00;
    endcase
  end

  assign arr_we     = we_q;
  assign arr_sel    = sel_q;
  assign arr_addr   = addr_q;
  assign arr_wdata  = wdata_q;
  assign mult_start = (st_q == ST_START);
  assign res_addr   = (st_q == ST_FETCH) ? idx_q : '0;
  assign tx_valid   = (st_q == ST_SEND_HI) || (st_q == ST_SEND_LO) || (st_q == ST_SEND_ERR);
  assign state      = {err_q, st_q};
  assign busy       = (st_q != ST_IDLE);

endmodule

// File: tb/tb_nc_mult_sequencer.sv
// Directed bench for nc_mult_sequencer with DIM=2, TIMEOUT_CYCLES=16.
module tb_nc_mult_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        arr_we;
  logic        arr_sel;
  logic [1:0]  arr_addr;
  logic [7:0]  arr_wdata;
  logic        mult_start;
  logic        mult_done;
  logic [1:0]  res_addr;
  logic [15:0] res_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [4:0]  state;
  logic        busy;

  nc_mult_sequencer #(.DIM(2), .TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET), .rx_valid(rx_valid), .rx_data(rx_data),
    .arr_we(arr_we), .arr_sel(arr_sel), .arr_addr(arr_addr), .arr_wdata(arr_wdata),
    .mult_start(mult_start), .mult_done(mult_done), .res_addr(res_addr),
    .res_data(res_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .state(state), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Result memory of the multiplier: read data one cycle after the address.
  logic [15:0] res_mem [4];
  always @(posedge CLK) res_data <= res_mem[res_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ms_count = 0;
  int ms_cyc = -1;
  int first_txv = -1;
  logic prev_wait = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [31:0] wr_log [$];
  logic [7:0]  tx_log [$];
  logic [7:0]  exp_tx [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observe the current cycle (at the falling edge), then advance one cycle.
  task automatic step();
    if (prev_wait) begin
      chk("tx_hold_valid", 32'(tx_valid), 32'd1);
      chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
    end
    prev_wait = tx_valid && !tx_ready;
    prev_data = tx_data;
    if (tx_valid) begin
      chk("txv_in_send", 32'(state[3:0] >= 4'd7 && state[3:0] <= 4'd9), 32'd1);
      if (first_txv < 0) first_txv = cyc;
    end
    if (arr_we) wr_log.push_back(32'({arr_sel, arr_addr, arr_wdata}));
    if (mult_start) begin ms_count++; ms_cyc = cyc; end
    if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    chk("reach_idle", 32'(busy), 32'd0);
  endtask

  task automatic wait_st(input logic [3:0] s, input int budget);
    int n = 0;
    while (state[3:0] != s && n < budget) begin step(); n++; end
    chk("reach_state", 32'(state[3:0]), 32'(s));
  endtask

  task automatic check_stream();
    chk("tx_count", 32'(tx_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < tx_log.size()) chk("tx_byte", 32'(tx_log[i]), 32'(exp_tx[i]));
  endtask

  initial begin
    int last_cyc, done_cyc, wait_cyc, stall;
    logic hs;
    res_mem[0] = 16'd19; res_mem[1] = 16'd22; res_mem[2] = 16'd43; res_mem[3] = 16'd50;
    exp_tx = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
    RESET = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mult_done = 1'b0; tx_ready = 1'b1;
    @(negedge CLK);
    step();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", 32'({arr_we, arr_sel, arr_addr, arr_wdata, mult_start, res_addr, tx_valid, tx_data}), 32'h0);
    RESET = 1'b0;
    step();

    // Unknown command sets err and writes nothing.
    send_byte(8'h12);
    step();
    chk("bad_cmd_state", 32'(state), 32'h10);
    chk("bad_cmd_writes", 32'(wr_log.size()), 32'd0);

    // Full load: 0xA5, A = 1..4, B = 5..8.
    send_byte(8'hA5);
    chk("loada_state", 32'(state), 32'h01);
    for (int i = 0; i < 8; i++) begin
      last_cyc = cyc;
      send_byte(8'(i + 1));
    end
    begin
      int n = 0;
      while (ms_count == 0 && n < 10) begin step(); n++; end
    end
    chk("start_latency", 32'(ms_cyc - last_cyc), 32'd2);
    chk("wr_count", 32'(wr_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < wr_log.size()) chk("wr_entry", wr_log[i], 32'({1'(i / 4), 2'(i % 4), 8'(i + 1)}));
    chk("wait_state", 32'(state), 32'h04);

    // Byte during WAIT is dropped; done 10 cycles after start.
    send_byte(8'h12);
    repeat (8) step();
    chk("wait_drop_state", 32'(state), 32'h04);
    first_txv = -1;
    mult_done = 1'b1;
    done_cyc = cyc;
    step();
    mult_done = 1'b0;
    chk("fetch_state", 32'(state), 32'h05);
    chk("fetch_addr", 32'(res_addr), 32'd0);
    run_idle(100);
    chk("idle_cycle", 32'(cyc - done_cyc), 32'd17);
    chk("first_txv", 32'(first_txv - done_cyc), 32'd3);
    chk("ms_once", 32'(ms_count), 32'd1);
    chk("wr_after_wait", 32'(wr_log.size()), 32'd8);
    check_stream();

    // Send-only with tx_ready stalls before every byte.
    tx_log.delete();
    send_byte(8'h3C);
    stall = $urandom_range(1, 5);
    begin
      int n = 0;
      while (busy && n < 400) begin
        if (tx_valid && stall > 0) begin tx_ready = 1'b0; stall--; end
        else tx_ready = 1'b1;
        hs = tx_valid && tx_ready;
        step();
        n++;
        if (hs) stall = $urandom_range(1, 5);
      end
    end
    tx_ready = 1'b1;
    chk("stall_idle", 32'(state), 32'h00);
    check_stream();

    // Timeout: no mult_done.
    tx_log.delete();
    send_byte(8'h5A);
    wait_st(4'd4, 10);
    wait_cyc = cyc;
    wait_st(4'd9, 40);
    chk("timeout_cycles", 32'(cyc - wait_cyc), 32'd16);
    chk("send_err_state", 32'(state), 32'h19);
    step();
    chk("err_byte_count", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) chk("err_byte", 32'(tx_log[0]), 32'hEE);
    repeat (3) step();
    chk("err_persists", 32'(state), 32'h10);
    tx_log.delete();
    send_byte(8'h3C);
    chk("err_cleared", 32'(state), 32'h05);
    run_idle(100);
    check_stream();

    // mult_done on the last WAIT cycle wins over the timeout.
    tx_log.delete();
    send_byte(8'h5A);
    wait_st(4'd4, 10);
    repeat (15) step();
    chk("wait_last_cycle", 32'(state), 32'h04);
    mult_done = 1'b1;
    step();
    mult_done = 1'b0;
    chk("done_wins", 32'(state), 32'h05);
    run_idle(100);
    check_stream();

    // Reset in the middle of LOAD_B, then send-only.
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) send_byte(8'h40 + 8'(i));
    step();
    chk("mid_loadb", 32'(state), 32'h02);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("mid_rst_state", 32'(state), 32'h00);
    chk("mid_rst_outs", 32'({arr_we, arr_sel, arr_addr, arr_wdata, mult_start, res_addr, tx_valid, tx_data, busy}), 32'h0);
    wr_log.delete();
    tx_log.delete();
    send_byte(8'h3C);
    run_idle(100);
    chk("post_rst_writes", 32'(wr_log.size()), 32'd0);
    check_stream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
